decode_issue_ctrl: RTL and testbench

//  Decode-stage sequencer between fetch and execute. Buffers fetched instructions in a

---
 rtl/decode_issue_ctrl_if.sv | 56 +++++
 rtl/decode_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_ctrl_pkg / decode_issue_ctrl_if
// Purpose  : Shared immediate-extension select type and the bus interface
//            that groups the fetch, flush, EX-forwarding and issue signals
//            of decode_issue_ctrl.
// Ports    : fetch  : f_valid, f_ready, f_instr[31:0], f_pc[63:0]
//            control: flush, ex_is_load, ex_rd[4:0]
//            issue  : d_valid, d_ready, d_instr[31:0], d_pc[63:0],
//                     d_imm[19:0], d_im_ext, bubble_cnt[CNT_W-1:0]
//            modport slave  = the decode stage (drives f_ready and d_*)
//            modport master = the surrounding pipeline / testbench
// Revision : 1.0  initial release
// ============================================================================
package decode_issue_ctrl_pkg;
  typedef enum logic [2:0] {
    EXT_NULL = 3'd0,
    EXT_ADDI = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_SD   = 3'd3,
    EXT_JAL  = 3'd4,
    EXT_BEQ  = 3'd5
  } im_ext_t;
endpackage

interface decode_issue_ctrl_if #(
  parameter int CNT_W = 32
);
  import decode_issue_ctrl_pkg::*;

  logic             f_valid;
  logic             f_ready;
  logic [31:0]      f_instr;
  logic [63:0]      f_pc;
  logic             flush;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic             d_valid;
  logic             d_ready;
  logic [31:0]      d_instr;
  logic [63:0]      d_pc;
  logic [19:0]      d_imm;
  im_ext_t          d_im_ext;
  logic [CNT_W-1:0] bubble_cnt;

  modport slave (
    input  f_valid, f_instr, f_pc, flush, ex_is_load, ex_rd, d_ready,
    output f_ready, d_valid, d_instr, d_pc, d_imm, d_im_ext, bubble_cnt
  );

  modport master (
    output f_valid, f_instr, f_pc, flush, ex_is_load, ex_rd, d_ready,
    input  f_ready, d_valid, d_instr, d_pc, d_imm, d_im_ext, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_ctrl
// Purpose  : Decode-stage sequencer. Buffers fetched instructions in a
//            DEPTH-entry FIFO, inserts one-cycle load-use bubbles, handles
//            redirect flushes and decodes the raw immediate field and its
//            extension select for the head instruction.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - decode_issue_ctrl_if.slave (fetch / control / issue)
// Revision : 1.0  initial release
// ============================================================================
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  decode_issue_ctrl_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [63:0]      r_pc_mem    [DEPTH];
  logic [CNT_W-1:0] r_bubble_cnt;
  // Head was already offered (d_valid=1) but not yet taken; it must keep
  // d_valid high, so the hazard check no longer applies to it.
  logic             r_held;

  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_head_instr;
  logic [63:0]      w_head_pc;
  logic             w_hazard;
  logic             w_d_valid;
  logic             w_bubble;
  logic             w_f_ready;
  logic             w_enq;
  logic             w_deq;
  logic [31:0]      w_d_instr;
  logic [19:0]      w_imm;
  im_ext_t          w_im_ext;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_head_instr = r_instr_mem[r_rd_ptr[AW-1:0]];
  assign w_head_pc    = r_pc_mem[r_rd_ptr[AW-1:0]];

  assign w_hazard = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == w_head_instr[19:15]) ||
                     (bus.ex_rd == w_head_instr[24:20]));

  always_comb begin
    w_state_nxt = r_state;
    w_d_valid   = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_d_valid = !w_empty && (!w_hazard || r_held);
        if (!w_empty && w_hazard && !r_held) begin
          w_state_nxt = ST_HOLD;
          w_bubble    = 1'b1;
        end
      end
      ST_HOLD:  w_state_nxt = ST_RUN;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
    // Redirect overrides everything, including a pending bubble.
    if (bus.flush) begin
      w_state_nxt = ST_FLUSH;
      w_bubble    = 1'b0;
    end
  end

  // No bypass: a full buffer refuses even when it dequeues this cycle.
  assign w_f_ready = !w_full && (r_state != ST_FLUSH);
  assign w_enq     = bus.f_valid && w_f_ready && !bus.flush;
  assign w_deq     = w_d_valid && bus.d_ready && !bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_bubble_cnt <= '0;
      r_held       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_d_valid && !bus.d_ready && !bus.flush;
      if (w_bubble) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: it is only observable through a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_instr_mem[r_wr_ptr[AW-1:0]] <= bus.f_instr;
      r_pc_mem[r_wr_ptr[AW-1:0]]    <= bus.f_pc;
    end
  end

  assign w_d_instr = w_d_valid ? w_head_instr : 32'd0;

  // Decoding the gated word keeps d_imm/d_im_ext at 0/EXT_NULL when idle.
  always_comb begin
    w_imm    = 20'd0;
    w_im_ext = EXT_NULL;
    case (w_d_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_im_ext = EXT_ADDI;
        w_imm    = {8'd0, w_d_instr[31:20]};
      end
      7'b0110111, 7'b0010111: begin
        w_im_ext = EXT_LUI;
        w_imm    = w_d_instr[31:12];
      end
      7'b0100011: begin
        w_im_ext = EXT_SD;
        w_imm    = {8'd0, w_d_instr[31:25], w_d_instr[11:7]};
      end
      7'b1101111: begin
        w_im_ext = EXT_JAL;
        w_imm    = {w_d_instr[31], w_d_instr[19:12], w_d_instr[20], w_d_instr[30:21]};
      end
      7'b1100011: begin
        w_im_ext = EXT_BEQ;
        w_imm    = {8'd0, w_d_instr[31], w_d_instr[7], w_d_instr[30:25], w_d_instr[11:8]};
      end
      default: begin
        w_im_ext = EXT_NULL;
        w_imm    = 20'd0;
      end
    endcase
  end

  assign bus.f_ready    = w_f_ready;
  assign bus.d_valid    = w_d_valid;
  assign bus.d_instr    = w_d_instr;
  assign bus.d_pc       = w_d_valid ? w_head_pc : 64'd0;
  assign bus.d_imm      = w_imm;
  assign bus.d_im_ext   = w_im_ext;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_ctrl
// Purpose  : Directed self-checking bench for decode_issue_ctrl. Inputs are
//            driven and outputs checked in the low clock phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  decode_issue_ctrl_if #(.CNT_W(32)) bus ();

  decode_issue_ctrl #(.DEPTH(2), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL rst_f_ready got=%0h want=1", bus.f_ready); end
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL rst_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.d_instr !== 32'd0) begin bad++; $display("FAIL rst_d_instr got=%0h want=0", bus.d_instr); end
    total++; if (bus.d_pc !== 64'd0) begin bad++; $display("FAIL rst_d_pc got=%0h want=0", bus.d_pc); end
    total++; if (bus.d_imm !== 20'd0) begin bad++; $display("FAIL rst_d_imm got=%0h want=0", bus.d_imm); end
    total++; if (bus.d_im_ext !== EXT_NULL) begin bad++; $display("FAIL rst_d_im_ext got=%0d want=%0d", bus.d_im_ext, EXT_NULL); end
    total++; if (bus.bubble_cnt !== 32'd0) begin bad++; $display("FAIL rst_bubble_cnt got=%0d want=0", bus.bubble_cnt); end
    reset = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL post_rst_f_ready got=%0h want=1", bus.f_ready); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    bus.d_ready = 1'b1; bus.f_valid = 1'b1; bus.f_instr = 32'h00500093; bus.f_pc = 64'h100;
    #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL stream_lat_d_valid got=%0h want=0", bus.d_valid); end
    @(negedge clk);
    bus.f_instr = 32'h00a00113; bus.f_pc = 64'h104;
    #1;
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL stream0_d_valid got=%0h want=1", bus.d_valid); end
    total++; if (bus.d_instr !== 32'h00500093) begin bad++; $display("FAIL stream0_d_instr got=%0h want=00500093", bus.d_instr); end
    total++; if (bus.d_pc !== 64'h100) begin bad++; $display("FAIL stream0_d_pc got=%0h want=100", bus.d_pc); end
    total++; if (bus.d_im_ext !== EXT_ADDI) begin bad++; $display("FAIL stream0_d_im_ext got=%0d want=%0d", bus.d_im_ext, EXT_ADDI); end
    total++; if (bus.d_imm !== 20'h00005) begin bad++; $display("FAIL stream0_d_imm got=%0h want=5", bus.d_imm); end
    @(negedge clk);
    bus.f_valid = 1'b0;
    #1;
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL stream1_d_valid got=%0h want=1", bus.d_valid); end
    total++; if (bus.d_instr !== 32'h00a00113) begin bad++; $display("FAIL stream1_d_instr got=%0h want=00a00113", bus.d_instr); end
    total++; if (bus.d_pc !== 64'h104) begin bad++; $display("FAIL stream1_d_pc got=%0h want=104", bus.d_pc); end
    total++; if (bus.d_imm !== 20'h0000a) begin bad++; $display("FAIL stream1_d_imm got=%0h want=a", bus.d_imm); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.d_instr !== 32'd0) begin bad++; $display("FAIL stream_drain_d_instr got=%0h want=0", bus.d_instr); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.d_ready = 1'b0; bus.f_valid = 1'b1; bus.f_instr = 32'h00100093; bus.f_pc = 64'h200;
    @(negedge clk);
    bus.f_instr = 32'h00200093; bus.f_pc = 64'h204;
    #1;
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL bp_one_f_ready got=%0h want=1", bus.f_ready); end
    total++; if (bus.d_instr !== 32'h00100093) begin bad++; $display("FAIL bp_one_d_instr got=%0h want=00100093", bus.d_instr); end
    @(negedge clk);
    bus.f_instr = 32'h00300093; bus.f_pc = 64'h208;
    #1;
    total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL bp_full_f_ready got=%0h want=0", bus.f_ready); end
    total++; if (bus.d_instr !== 32'h00100093) begin bad++; $display("FAIL bp_hold_d_instr got=%0h want=00100093", bus.d_instr); end
    @(negedge clk);
    bus.d_ready = 1'b1;
    #1;
    total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL bp_nobypass_f_ready got=%0h want=0", bus.f_ready); end
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL bp_stable_d_valid got=%0h want=1", bus.d_valid); end
    @(negedge clk); #1;
    total++; if (bus.d_instr !== 32'h00200093) begin bad++; $display("FAIL bp_second_d_instr got=%0h want=00200093", bus.d_instr); end
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen_f_ready got=%0h want=1", bus.f_ready); end
    @(negedge clk);
    bus.f_valid = 1'b0;
    #1;
    total++; if (bus.d_instr !== 32'h00300093) begin bad++; $display("FAIL bp_third_d_instr got=%0h want=00300093", bus.d_instr); end
    total++; if (bus.d_pc !== 64'h208) begin bad++; $display("FAIL bp_third_d_pc got=%0h want=208", bus.d_pc); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_d_valid got=%0h want=0", bus.d_valid); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    bus.d_ready = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd1;
    bus.f_valid = 1'b1; bus.f_instr = 32'h002081b3; bus.f_pc = 64'h300;
    @(negedge clk);
    bus.f_valid = 1'b0;
    #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL hz_detect_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.bubble_cnt !== 32'd0) begin bad++; $display("FAIL hz_detect_cnt got=%0d want=0", bus.bubble_cnt); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL hz_hold_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.bubble_cnt !== 32'd1) begin bad++; $display("FAIL hz_hold_cnt got=%0d want=1", bus.bubble_cnt); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL hz_persist_d_valid got=%0h want=0", bus.d_valid); end
    @(negedge clk);
    bus.ex_is_load = 1'b0;
    #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL hz_hold2_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.bubble_cnt !== 32'd2) begin bad++; $display("FAIL hz_hold2_cnt got=%0d want=2", bus.bubble_cnt); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL hz_issue_d_valid got=%0h want=1", bus.d_valid); end
    total++; if (bus.d_instr !== 32'h002081b3) begin bad++; $display("FAIL hz_issue_d_instr got=%0h want=002081b3", bus.d_instr); end
    total++; if (bus.d_im_ext !== EXT_NULL) begin bad++; $display("FAIL hz_issue_d_im_ext got=%0d want=%0d", bus.d_im_ext, EXT_NULL); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL hz_drain_d_valid got=%0h want=0", bus.d_valid); end
  endtask

  task automatic test_no_bubble_rd0();
    @(negedge clk);
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0;
    bus.f_valid = 1'b1; bus.f_instr = 32'h002081b3; bus.f_pc = 64'h310;
    @(negedge clk);
    bus.f_valid = 1'b0;
    #1;
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL rd0_d_valid got=%0h want=1", bus.d_valid); end
    @(negedge clk); #1;
    total++; if (bus.bubble_cnt !== 32'd2) begin bad++; $display("FAIL rd0_cnt got=%0d want=2", bus.bubble_cnt); end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.d_ready = 1'b0; bus.f_valid = 1'b1; bus.f_instr = 32'h00100093; bus.f_pc = 64'h400;
    @(negedge clk);
    bus.f_instr = 32'h00200093; bus.f_pc = 64'h404;
    @(negedge clk);
    bus.f_instr = 32'h00300093; bus.f_pc = 64'h408; bus.flush = 1'b1;
    #1;
    total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL fl_full_f_ready got=%0h want=0", bus.f_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.f_valid = 1'b0; bus.d_ready = 1'b1;
    #1;
    total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL fl_state_f_ready got=%0h want=0", bus.f_ready); end
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL fl_state_d_valid got=%0h want=0", bus.d_valid); end
    @(negedge clk); #1;
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL fl_after_f_ready got=%0h want=1", bus.f_ready); end
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL fl_empty_d_valid got=%0h want=0", bus.d_valid); end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL fl_dropped_d_valid got=%0h want=0", bus.d_valid); end
  endtask

  task automatic test_imm();
    logic [31:0] iv [4];
    im_ext_t     ev [4];
    logic [19:0] mv [4];
    iv[0] = 32'hff9ff0ef; ev[0] = EXT_JAL; mv[0] = 20'hffffc;
    iv[1] = 32'hfe000ee3; ev[1] = EXT_BEQ; mv[1] = 20'h00ffe;
    iv[2] = 32'h123450b7; ev[2] = EXT_LUI; mv[2] = 20'h12345;
    iv[3] = 32'h00113423; ev[3] = EXT_SD;  mv[3] = 20'h00008;
    bus.d_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.f_valid = 1'b1; bus.f_instr = iv[i]; bus.f_pc = 64'h600 + 64'(4 * i);
      end else begin
        bus.f_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        total++; if (bus.d_instr !== iv[i-1]) begin bad++; $display("FAIL imm%0d_d_instr got=%0h want=%0h", i-1, bus.d_instr, iv[i-1]); end
        total++; if (bus.d_im_ext !== ev[i-1]) begin bad++; $display("FAIL imm%0d_d_im_ext got=%0d want=%0d", i-1, bus.d_im_ext, ev[i-1]); end
        total++; if (bus.d_imm !== mv[i-1]) begin bad++; $display("FAIL imm%0d_d_imm got=%0h want=%0h", i-1, bus.d_imm, mv[i-1]); end
      end
    end
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL imm_drain_d_valid got=%0h want=0", bus.d_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.d_ready = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd1;
    bus.f_valid = 1'b1; bus.f_instr = 32'h002081b3; bus.f_pc = 64'h500;
    @(negedge clk);
    bus.f_instr = 32'h00500093; bus.f_pc = 64'h504;
    @(negedge clk);
    bus.f_valid = 1'b0;
    #1;
    total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL ar_full_f_ready got=%0h want=0", bus.f_ready); end
    total++; if (bus.bubble_cnt !== 32'd3) begin bad++; $display("FAIL ar_hold_cnt got=%0d want=3", bus.bubble_cnt); end
    #1 reset = 1'b0;
    #1;
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL ar_f_ready got=%0h want=1", bus.f_ready); end
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL ar_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.d_instr !== 32'd0) begin bad++; $display("FAIL ar_d_instr got=%0h want=0", bus.d_instr); end
    total++; if (bus.d_pc !== 64'd0) begin bad++; $display("FAIL ar_d_pc got=%0h want=0", bus.d_pc); end
    total++; if (bus.d_imm !== 20'd0) begin bad++; $display("FAIL ar_d_imm got=%0h want=0", bus.d_imm); end
    total++; if (bus.d_im_ext !== EXT_NULL) begin bad++; $display("FAIL ar_d_im_ext got=%0d want=%0d", bus.d_im_ext, EXT_NULL); end
    total++; if (bus.bubble_cnt !== 32'd0) begin bad++; $display("FAIL ar_bubble_cnt got=%0d want=0", bus.bubble_cnt); end
    reset = 1'b1;
    bus.ex_is_load = 1'b0;
    bus.d_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL ar_after_d_valid got=%0h want=0", bus.d_valid); end
    total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL ar_after_f_ready got=%0h want=1", bus.f_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.f_valid    = 1'b0;
    bus.f_instr    = 32'd0;
    bus.f_pc       = 64'd0;
    bus.flush      = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd      = 5'd0;
    bus.d_ready    = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_hazard();
    test_no_bubble_rd0();
    test_flush();
    test_imm();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
